// File: rtl/config_pkg.sv
// Minimal core configuration record; only the physical address width is consumed here.
package config_pkg;

  typedef struct packed {
    int unsigned PLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{PLEN: 32'd32};

endpackage

// File: rtl/pma_region_checker_pkg.sv
// Shared types and the region match function for the PMA region checker.
package pma_region_checker_pkg;
  import config_pkg::*;

  localparam cva6_cfg_t   PmaCfg     = cva6_cfg_empty;
  localparam int unsigned PLEN       = PmaCfg.PLEN;
  localparam int unsigned NrMaxRules = 64;

  typedef struct packed {
    logic ni;
    logic x;
    logic c;
  } pma_attr_t;

  typedef struct packed {
    logic            en;
    logic            lock;
    logic            ni;
    logic            x;
    logic            c;
    logic [PLEN-1:0] base;
    logic [PLEN-1:0] len;
  } pma_rule_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The end bound is computed one bit wider so a region reaching 2^PLEN never wraps to 0.
  function automatic logic pma_match(input pma_rule_t rule, input logic [PLEN-1:0] addr);
    logic [PLEN:0] w_end;
    w_end = {1'b0, rule.base} + {1'b0, rule.len};
    return rule.en && (rule.len != '0) && (addr >= rule.base) && ({1'b0, addr} < w_end);
  endfunction

endpackage

// File: rtl/pma_region_checker_if.sv
// Config and per-channel lookup signals of the PMA region checker.
interface pma_region_checker_if
  import pma_region_checker_pkg::*;
#(
  parameter int unsigned NrRules    = 16,
  parameter int unsigned NrChannels = 2
);
  localparam int unsigned IdxW    = idx_width(NrRules);
  localparam int unsigned CfgIdxW = $clog2(NrRules) + 1;

  logic                                cfg_valid_i;
  logic                                cfg_we_i;
  logic [CfgIdxW-1:0]                  cfg_idx_i;
  pma_rule_t                           cfg_wdata_i;
  logic                                cfg_rvalid_o;
  pma_rule_t                           cfg_rdata_o;
  logic                                cfg_err_o;

  logic [NrChannels-1:0]               req_valid_i;
  logic [NrChannels-1:0]               req_ready_o;
  logic [NrChannels-1:0][PLEN-1:0]     req_addr_i;
  logic [NrChannels-1:0]               rsp_valid_o;
  logic [NrChannels-1:0]               rsp_ready_i;
  pma_attr_t [NrChannels-1:0]          rsp_attr_o;
  logic [NrChannels-1:0]               rsp_hit_o;
  logic [NrChannels-1:0][IdxW-1:0]     rsp_idx_o;

  modport slave (
    input  cfg_valid_i, cfg_we_i, cfg_idx_i, cfg_wdata_i,
    output cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    input  req_valid_i, req_addr_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_attr_o, rsp_hit_o, rsp_idx_o
  );

  modport master (
    output cfg_valid_i, cfg_we_i, cfg_idx_i, cfg_wdata_i,
    input  cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    output req_valid_i, req_addr_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_attr_o, rsp_hit_o, rsp_idx_o
  );

endinterface

// File: rtl/pma_region_checker_lookup_ch.sv
// One lookup channel: match all rules, pick the lowest index, register the result.
module pma_region_checker_lookup_ch
  import pma_region_checker_pkg::*;
#(
  parameter int unsigned NrRules     = 16,
  parameter pma_attr_t   DefaultAttr = 3'b011,
  localparam int unsigned IdxW       = idx_width(NrRules)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  pma_rule_t [NrRules-1:0]  i_rules,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [PLEN-1:0]          i_req_addr,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output pma_attr_t                o_rsp_attr,
  output logic                     o_rsp_hit,
  output logic [IdxW-1:0]          o_rsp_idx
);

  logic [NrRules-1:0] w_match;
  logic [NrRules-1:0] w_unused_lock;
  logic               w_hit;
  logic [IdxW-1:0]    w_idx;
  pma_attr_t          w_attr;

  logic               r_vld_p1;
  pma_attr_t          r_attr_p1;
  logic               r_hit_p1;
  logic [IdxW-1:0]    r_idx_p1;

  always_comb begin
    w_match       = '0;
    w_unused_lock = '0;
    for (int k = 0; k < NrRules; k++) begin
      w_match[k]       = pma_match(i_rules[k], i_req_addr);
      w_unused_lock[k] = i_rules[k].lock;
    end
  end

  always_comb begin
    w_hit = |w_match;
    w_idx = '0;
    for (int k = NrRules - 1; k >= 0; k--) begin
      if (w_match[k]) w_idx = IdxW'(k);
    end
    if (w_hit) begin
      w_attr = '{ni: i_rules[w_idx].ni, x: i_rules[w_idx].x, c: i_rules[w_idx].c};
    end else begin
      w_attr = DefaultAttr;
    end
  end

  assign o_req_ready = !r_vld_p1 || i_rsp_ready;

  // p0 -> p1: resolved result captured on accept, held while the consumer stalls
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1  <= 1'b0;
      r_attr_p1 <= '0;
      r_hit_p1  <= 1'b0;
      r_idx_p1  <= '0;
    end else if (o_req_ready) begin
      r_vld_p1 <= i_req_valid;
      if (i_req_valid) begin
        r_attr_p1 <= w_attr;
        r_hit_p1  <= w_hit;
        r_idx_p1  <= w_idx;
      end
    end
  end

  assign o_rsp_valid = r_vld_p1;
  assign o_rsp_attr  = r_attr_p1;
  assign o_rsp_hit   = r_hit_p1;
  assign o_rsp_idx   = r_idx_p1;

endmodule

// File: rtl/pma_region_checker.sv
// Runtime-programmable PMA attribute table with lockable entries and per-channel lookups.
module pma_region_checker
  import pma_region_checker_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
  parameter int unsigned           NrRules     = 16,
  parameter int unsigned           NrChannels  = 2,
  parameter pma_attr_t             DefaultAttr = 3'b011
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pma_region_checker_if.slave   bus
);

  localparam int unsigned AddrW   = CVA6Cfg.PLEN;
  localparam int unsigned IdxW    = idx_width(NrRules);
  localparam int unsigned CfgIdxW = $clog2(NrRules) + 1;

  pma_rule_t [NrRules-1:0] r_rules;
  logic                    r_cfg_rvalid;
  pma_rule_t               r_cfg_rdata;
  logic                    r_cfg_err;

  logic                    w_cfg_oor;
  logic [IdxW-1:0]         w_cfg_sel;
  pma_rule_t               w_cfg_entry;
  logic                    w_cfg_wr_ok;

  assign w_cfg_oor   = (bus.cfg_idx_i >= CfgIdxW'(NrRules));
  assign w_cfg_sel   = bus.cfg_idx_i[IdxW-1:0];
  assign w_cfg_entry = w_cfg_oor ? '0 : r_rules[w_cfg_sel];
  assign w_cfg_wr_ok = bus.cfg_valid_i && bus.cfg_we_i && !w_cfg_oor && !w_cfg_entry.lock;

  // Table update and config response; lookups in the same cycle still see the old table
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rules      <= '0;
      r_cfg_rvalid <= 1'b0;
      r_cfg_rdata  <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      if (w_cfg_wr_ok) r_rules[w_cfg_sel] <= bus.cfg_wdata_i;
      r_cfg_rvalid <= bus.cfg_valid_i;
      r_cfg_err    <= bus.cfg_valid_i && (w_cfg_oor || (bus.cfg_we_i && w_cfg_entry.lock));
      if (bus.cfg_valid_i) r_cfg_rdata <= w_cfg_wr_ok ? bus.cfg_wdata_i : w_cfg_entry;
    end
  end

  assign bus.cfg_rvalid_o = r_cfg_rvalid;
  assign bus.cfg_rdata_o  = r_cfg_rdata;
  assign bus.cfg_err_o    = r_cfg_err;

  for (genvar g = 0; g < NrChannels; g++) begin : g_ch
    logic [AddrW-1:0] w_addr;
    logic             w_ready;
    logic             w_valid;
    pma_attr_t        w_attr;
    logic             w_hit;
    logic [IdxW-1:0]  w_idx;

    assign w_addr = bus.req_addr_i[g];

    pma_region_checker_lookup_ch #(
      .NrRules     (NrRules),
      .DefaultAttr (DefaultAttr)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_rules     (r_rules),
      .i_req_valid (bus.req_valid_i[g]),
      .o_req_ready (w_ready),
      .i_req_addr  (w_addr),
      .o_rsp_valid (w_valid),
      .i_rsp_ready (bus.rsp_ready_i[g]),
      .o_rsp_attr  (w_attr),
      .o_rsp_hit   (w_hit),
      .o_rsp_idx   (w_idx)
    );

    assign bus.req_ready_o[g] = w_ready;
    assign bus.rsp_valid_o[g] = w_valid;
    assign bus.rsp_attr_o[g]  = w_attr;
    assign bus.rsp_hit_o[g]   = w_hit;
    assign bus.rsp_idx_o[g]   = w_idx;
  end

endmodule

// File: tb/tb_pma_region_checker.sv
// Directed bench for pma_region_checker: table-driven lookups plus hand-written corner sequences.
module tb_pma_region_checker;
  import pma_region_checker_pkg::*;

  localparam int unsigned NR = 16;
  localparam int unsigned NC = 2;
  localparam int unsigned NV = 17;

  typedef struct {
    int          phase;
    int          ch;
    logic [31:0] addr;
    logic        hit;
    logic [3:0]  idx;
    logic [2:0]  attr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pma_region_checker_if #(.NrRules(NR), .NrChannels(NC)) bus ();

  pma_region_checker #(
    .CVA6Cfg     (config_pkg::cva6_cfg_empty),
    .NrRules     (NR),
    .NrChannels  (NC),
    .DefaultAttr (3'b011)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic pma_rule_t mk(input logic en, input logic lock, input logic ni, input logic x,
                                   input logic c, input logic [31:0] base, input logic [31:0] len);
    pma_rule_t r;
    r.en = en; r.lock = lock; r.ni = ni; r.x = x; r.c = c; r.base = base; r.len = len;
    return r;
  endfunction

  task automatic cfg(input logic we, input logic [4:0] idx, input pma_rule_t wd,
                     input logic exp_err, input pma_rule_t exp_rd, input string tag);
    bus.cfg_valid_i = 1'b1;
    bus.cfg_we_i    = we;
    bus.cfg_idx_i   = idx;
    bus.cfg_wdata_i = wd;
    tick();
    bus.cfg_valid_i = 1'b0;
    bus.cfg_we_i    = 1'b0;
    chk({tag, "_rvalid"}, bus.cfg_rvalid_o, 1'b1);
    chk({tag, "_err"}, bus.cfg_err_o, exp_err);
    chk({tag, "_rdata"}, bus.cfg_rdata_o, exp_rd);
  endtask

  task automatic chk_rsp(input int ch, input logic hit, input logic [3:0] idx,
                         input logic [2:0] attr, input string tag);
    chk({tag, "_vld"}, bus.rsp_valid_o[ch], 1'b1);
    chk({tag, "_hit"}, bus.rsp_hit_o[ch], hit);
    chk({tag, "_idx"}, bus.rsp_idx_o[ch], idx);
    chk({tag, "_attr"}, bus.rsp_attr_o[ch], attr);
  endtask

  task automatic do_lookup(input int ch, input logic [31:0] addr, input logic hit,
                           input logic [3:0] idx, input logic [2:0] attr, input string tag);
    bus.req_valid_i[ch] = 1'b1;
    bus.req_addr_i[ch]  = addr;
    #1;
    chk({tag, "_rdy"}, bus.req_ready_o[ch], 1'b1);
    tick();
    bus.req_valid_i[ch] = 1'b0;
    chk_rsp(ch, hit, idx, attr, tag);
  endtask

  task automatic run_phase(input int p);
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].phase == p)
        do_lookup(vecs[i].ch, vecs[i].addr, vecs[i].hit, vecs[i].idx, vecs[i].attr,
                  $sformatf("vec%0d", i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pma_rule_t e0, e1, e2, e3, e4, e5, e5b, e6;
    logic [31:0] s_addr[3];
    logic [3:0]  s_idx[3];
    logic [2:0]  s_attr[3];

    // phase, ch, addr, hit, idx, attr{ni,x,c}
    vecs[0]  = '{0, 0, 32'h8000_0000, 1'b0, 4'd0, 3'b011};
    vecs[1]  = '{0, 1, 32'h0000_0000, 1'b0, 4'd0, 3'b011};
    vecs[2]  = '{1, 0, 32'h1000_0FFF, 1'b1, 4'd2, 3'b100};
    vecs[3]  = '{1, 1, 32'h1000_1000, 1'b0, 4'd0, 3'b011};
    vecs[4]  = '{1, 0, 32'h1000_0000, 1'b1, 4'd2, 3'b100};
    vecs[5]  = '{1, 1, 32'h0FFF_FFFF, 1'b0, 4'd0, 3'b011};
    vecs[6]  = '{2, 0, 32'h1000_0010, 1'b1, 4'd0, 3'b011};
    vecs[7]  = '{2, 1, 32'h1000_0FFF, 1'b1, 4'd0, 3'b011};
    vecs[8]  = '{2, 0, 32'h1001_0000, 1'b0, 4'd0, 3'b011};
    vecs[9]  = '{2, 1, 32'hFFFF_FFFF, 1'b1, 4'd3, 3'b110};
    vecs[10] = '{2, 0, 32'h0000_0000, 1'b0, 4'd0, 3'b011};
    vecs[11] = '{2, 1, 32'hFFFF_EFFF, 1'b0, 4'd0, 3'b011};
    vecs[12] = '{2, 0, 32'hFFFF_F000, 1'b1, 4'd3, 3'b110};
    vecs[13] = '{2, 1, 32'h2000_0000, 1'b0, 4'd0, 3'b011};
    vecs[14] = '{2, 0, 32'h3000_0000, 1'b0, 4'd0, 3'b011};
    vecs[15] = '{3, 0, 32'h4000_0010, 1'b1, 4'd5, 3'b001};
    vecs[16] = '{3, 1, 32'h5000_0000, 1'b0, 4'd0, 3'b011};

    e0  = mk(1, 0, 0, 1, 1, 32'h1000_0000, 32'h0001_0000);
    e1  = mk(1, 0, 1, 1, 1, 32'h6000_0000, 32'h0000_1000);
    e2  = mk(1, 0, 1, 0, 0, 32'h1000_0000, 32'h0000_1000);
    e3  = mk(1, 0, 1, 1, 0, 32'hFFFF_F000, 32'h0000_1000);
    e4  = mk(0, 0, 1, 1, 1, 32'h2000_0000, 32'h0000_0100);
    e5  = mk(1, 1, 0, 0, 1, 32'h4000_0000, 32'h0000_0100);
    e5b = mk(1, 0, 0, 0, 1, 32'h5000_0000, 32'h0000_0100);
    e6  = mk(1, 0, 1, 1, 1, 32'h3000_0000, 32'h0000_0000);

    rst             = 1'b1;
    bus.cfg_valid_i = 1'b0;
    bus.cfg_we_i    = 1'b0;
    bus.cfg_idx_i   = '0;
    bus.cfg_wdata_i = '0;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.rsp_ready_i = '1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_rsp_valid", bus.rsp_valid_o, 2'b00);
    chk("rst_rsp_attr", bus.rsp_attr_o, 6'b0);
    chk("rst_rsp_hit", bus.rsp_hit_o, 2'b00);
    chk("rst_rsp_idx", bus.rsp_idx_o, 8'h00);
    chk("rst_cfg_rvalid", bus.cfg_rvalid_o, 1'b0);
    chk("rst_cfg_rdata", bus.cfg_rdata_o, '0);
    chk("rst_cfg_err", bus.cfg_err_o, 1'b0);
    chk("rst_req_ready", bus.req_ready_o, 2'b11);

    run_phase(0);

    cfg(1'b1, 5'd2, e2, 1'b0, e2, "wr_e2");
    run_phase(1);

    cfg(1'b1, 5'd0, e0, 1'b0, e0, "wr_e0");
    cfg(1'b1, 5'd3, e3, 1'b0, e3, "wr_e3");
    cfg(1'b1, 5'd4, e4, 1'b0, e4, "wr_e4");
    cfg(1'b1, 5'd6, e6, 1'b0, e6, "wr_e6");
    run_phase(2);

    // Locking, refused rewrite, out-of-range index, single-cycle response pulse
    cfg(1'b1, 5'd5, e5, 1'b0, e5, "wr_e5_lock");
    cfg(1'b1, 5'd5, e5b, 1'b1, e5, "wr_e5_locked");
    cfg(1'b0, 5'd5, '0, 1'b0, e5, "rd_e5");
    cfg(1'b1, 5'd16, e5b, 1'b1, '0, "wr_oor");
    cfg(1'b0, 5'd16, '0, 1'b1, '0, "rd_oor");
    tick();
    chk("cfg_rvalid_pulse", bus.cfg_rvalid_o, 1'b0);
    chk("cfg_err_pulse", bus.cfg_err_o, 1'b0);
    run_phase(3);

    // Same-cycle write and lookup: the lookup uses the old table
    bus.cfg_valid_i     = 1'b1;
    bus.cfg_we_i        = 1'b1;
    bus.cfg_idx_i       = 5'd1;
    bus.cfg_wdata_i     = e1;
    bus.req_valid_i[1]  = 1'b1;
    bus.req_addr_i[1]   = 32'h6000_0010;
    tick();
    bus.cfg_valid_i = 1'b0;
    bus.cfg_we_i    = 1'b0;
    chk("same_cfg_err", bus.cfg_err_o, 1'b0);
    chk_rsp(1, 1'b0, 4'd0, 3'b011, "same_old");
    tick();
    bus.req_valid_i[1] = 1'b0;
    chk_rsp(1, 1'b1, 4'd1, 3'b111, "same_new");

    // Backpressure on ch0 while ch1 streams one lookup per cycle
    s_addr[0] = 32'h1000_0FFF; s_idx[0] = 4'd0; s_attr[0] = 3'b011;
    s_addr[1] = 32'h6000_0800; s_idx[1] = 4'd1; s_attr[1] = 3'b111;
    s_addr[2] = 32'hFFFF_FFFF; s_idx[2] = 4'd3; s_attr[2] = 3'b110;
    bus.rsp_ready_i[0] = 1'b0;
    bus.req_valid_i[0] = 1'b1;
    bus.req_addr_i[0]  = 32'h4000_0000;
    tick();
    chk_rsp(0, 1'b1, 4'd5, 3'b001, "bp_cap");
    bus.req_addr_i[0] = 32'h8000_0000;
    for (int c = 0; c < 3; c++) begin
      bus.req_valid_i[1] = 1'b1;
      bus.req_addr_i[1]  = s_addr[c];
      #1;
      chk($sformatf("bp_rdy0_%0d", c), bus.req_ready_o[0], 1'b0);
      chk($sformatf("bp_rdy1_%0d", c), bus.req_ready_o[1], 1'b1);
      tick();
      chk_rsp(0, 1'b1, 4'd5, 3'b001, $sformatf("bp_hold%0d", c));
      chk_rsp(1, 1'b1, s_idx[c], s_attr[c], $sformatf("bp_ch1_%0d", c));
    end
    bus.req_valid_i[1] = 1'b0;
    bus.rsp_ready_i[0] = 1'b1;
    #1;
    chk("bp_release_rdy", bus.req_ready_o[0], 1'b1);
    tick();
    bus.req_valid_i[0] = 1'b0;
    chk_rsp(0, 1'b0, 4'd0, 3'b011, "bp_next");
    tick();
    chk("bp_drain_vld0", bus.rsp_valid_o[0], 1'b0);
    chk("bp_drain_vld1", bus.rsp_valid_o[1], 1'b0);

    // Reset with a stalled response in flight, then confirm the table and locks are cleared
    bus.rsp_ready_i[0] = 1'b0;
    bus.req_valid_i[0] = 1'b1;
    bus.req_addr_i[0]  = 32'h4000_0000;
    tick();
    bus.req_valid_i[0] = 1'b0;
    chk("mid_vld_before", bus.rsp_valid_o[0], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready_i = '1;
    chk("mid_rsp_valid", bus.rsp_valid_o, 2'b00);
    chk("mid_rsp_hit", bus.rsp_hit_o, 2'b00);
    chk("mid_rsp_idx", bus.rsp_idx_o, 8'h00);
    chk("mid_rsp_attr", bus.rsp_attr_o, 6'b0);
    do_lookup(0, 32'h4000_0010, 1'b0, 4'd0, 3'b011, "mid_cleared");
    cfg(1'b0, 5'd2, '0, 1'b0, '0, "mid_rd_e2");
    cfg(1'b1, 5'd5, e5b, 1'b0, e5b, "mid_wr_e5");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pma_region_checker.md
Name: pma_region_checker

Overview:
- Runtime-programmable PMA attribute lookup: a table of NrRules address regions, each carrying non-idempotent, execute and cacheable attributes.
- Serves NrChannels independent lookup channels. Each channel has a one-stage valid/ready pipeline.
- Successor to the static configuration-time region checks. Adds writable and lockable entries, lowest-index-priority matching, per-channel pipelined responses, and a matched-rule index.
- Sits between the MMU/PMP outputs and the fetch, load and store units.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; CVA6Cfg.PLEN gives the address width.
- NrRules, 16, number of table entries; range 1..NrMaxRules.
- NrChannels, 2, number of independent lookup channels; must be >= 1.
- DefaultAttr, 3'b011, attributes {ni,x,c} returned when no enabled rule matches.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cfg_valid_i  in  1  config access request; always accepted
- cfg_we_i  in  1  1 = write, 0 = read
- cfg_idx_i  in  $clog2(NrRules)+1  entry index; the extra MSB allows out-of-range detection
- cfg_wdata_i  in  pma_rule_t  {en, lock, ni, x, c, base[PLEN], len[PLEN]}
- cfg_rvalid_o  out  1  response valid, asserted one cycle after cfg_valid_i
- cfg_rdata_o  out  pma_rule_t  read data, or the stored entry after a write
- cfg_err_o  out  1  access error: index out of range, or write to a locked entry
- req_valid_i  in  NrChannels  lookup request valid, per channel
- req_ready_o  out  NrChannels  lookup request ready, per channel
- req_addr_i  in  NrChannels x PLEN  lookup physical address
- rsp_valid_o  out  NrChannels  response valid
- rsp_ready_i  in  NrChannels  response ready
- rsp_attr_o  out  NrChannels x pma_attr_t  resolved {ni,x,c}
- rsp_hit_o  out  NrChannels  1 if an enabled rule matched
- rsp_idx_o  out  NrChannels x $clog2(NrRules)  index of the matching rule; 0 when there is no hit

Behaviour:
- Reset (synchronous, rst_i high at a clock edge):
  - All table entries are cleared to '0, so every entry is disabled and unlocked.
  - Outputs after reset: rsp_valid_o='0, rsp_attr_o='0, rsp_hit_o='0, rsp_idx_o='0, cfg_rvalid_o=0, cfg_rdata_o='0, cfg_err_o=0.
  - Reset asserted mid-operation drops in-flight responses without a handshake.
- Match rule for entry k against address a:
  - Match when en and len!=0 and a>=base and {1'b0,a} < ({1'b0,base}+{1'b0,len}).
  - The comparison is PLEN+1 bits wide, so it has no wrap-around. A region whose end reaches 2^PLEN matches up to the top address.
- Resolution:
  - The lowest matching index wins, via a priority encoder.
  - Hit: attr = entry attributes, hit=1, idx=k.
  - No hit: attr = DefaultAttr, hit=0, idx=0.
- Lookup pipeline, independent per channel:
  - req_ready_o[i] = !rsp_valid_o[i] || rsp_ready_i[i].
  - On req_valid&&req_ready, the resolved result is registered; rsp_valid rises next cycle. Latency is 1 cycle.
  - rsp_valid without rsp_ready: all rsp_* outputs are held stable.
  - Sustained throughput is 1 lookup per cycle per channel.
- Config write (cfg_valid_i && cfg_we_i):
  - Index out of range (>= NrRules), or target entry lock=1: no update, cfg_err_o=1.
  - Otherwise the entry is written at the clock edge.
  - Writing lock=1 makes the entry immutable until reset.
  - Response next cycle: cfg_rvalid_o=1, cfg_rdata_o = entry value after the write (or '0 when out of range).
- Config read: response next cycle with cfg_rdata_o = entry value. Out-of-range index gives rdata='0, err=1.
- Simultaneous config write and lookup accept in the same cycle: the lookup sees the OLD table contents; the new value applies to lookups accepted from the next cycle.
- A response held under backpressure is not re-evaluated when the table changes.
- cfg_rvalid_o and cfg_err_o are single-cycle pulses.

Decomposition:
- Package pma_pkg (imports config_pkg) holds:
  - pma_attr_t {ni,x,c}
  - pma_rule_t parametrised by PLEN via a CVA6Cfg-typed localparam
  - function pma_match(rule, addr) carrying the PLEN+1-bit check
- Sub-module pma_lookup_ch: one channel's combinational match, priority encoder and output register. Instantiated NrChannels times over the shared table.

Test Plan:
- Reset, then lookup addr 0x8000_0000 on ch0 -> rsp next cycle: hit=0, attr=3'b011, idx=0; req_ready stays 1 throughout.
- Write entry 2 {en=1, base=0x1000_0000, len=0x1000, ni=1, x=0, c=0}, then look up 0x1000_0FFF and 0x1000_1000 -> first: hit=1, idx=2, attr=3'b100; second: hit=0, default attributes.
- Overlapping entry 0 {base=0x1000_0000, len=0x10000, c=1, x=1, ni=0} plus entry 2 above, look up 0x1000_0010 -> idx=0, attr=3'b011 (lowest index wins).
- Write entry 5 with lock=1, rewrite entry 5 with different base, write index 16 (NrRules=16) -> second write: cfg_err_o=1, cfg_rdata_o shows the unchanged entry; index 16: err=1, rdata='0.
- Same-cycle write of entry 1 and ch1 lookup inside the new region -> ch1 sees no hit; a lookup on the following cycle hits idx=1.
- Ch0 rsp_ready_i=0 for 3 cycles with a new request pending -> req_ready_o[0]=0, rsp fields stable; ch1 continues at 1/cycle.
- Region base=2^PLEN-0x1000, len=0x1000 -> top address hits, no wrap-around false match at address 0.
